// File: rtl/ifetch_unit.sv
// ifetch_unit: owns the PC and keeps one instruction-memory fetch outstanding at a time.
// Returned words are buffered with their PC in a small FIFO that feeds decode over valid/ready.
// A redirect flushes the FIFO and restarts fetch at the target. If the redirect arrives while a
// request is still waiting for its ack, the fetch unit waits for that ack and discards the word.
// Optional build macro IFETCH_MISALIGN_TRAP_EN: a redirect to a target that is not word aligned
// raises a one-cycle misalign_err and halts fetch. Without the macro the low two target bits are
// ignored.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misalign_err
);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    // state | meaning
    // FETCH | normal operation: request, push acked words, advance pc
    // DROP  | stale request outstanding after a redirect; wait for its ack, discard the data
    // HALT  | misaligned redirect trapped; no requests until an aligned redirect (macro only)
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
`ifdef IFETCH_MISALIGN_TRAP_EN
        ST_HALT  = 2'd2,
`endif
        ST_DROP  = 2'd1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   target_q, target_d;
    logic          req_q, req_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [31:0]   fifo_pc    [FIFO_DEPTH];
    logic          push, pop, flush, acked;
    logic [31:0]   tgt;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic misal;
    logic halt_pend_q, halt_pend_d;
    logic err_q;
    assign tgt          = redirect_pc;
    assign misal        = |redirect_pc[1:0];
    assign misalign_err = err_q;
`else
    logic [1:0] unused_pc_lsb;
    assign unused_pc_lsb = redirect_pc[1:0];
    assign tgt           = {redirect_pc[31:2], 2'b00};
    assign misalign_err  = 1'b0;
`endif

    assign acked       = req_q && imem_ack;
    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? fifo_instr[rd_ptr_q] : NOP;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr_q] : 32'h0;

    // Next-state, pc, FIFO bookkeeping and request generation; redirect outranks push/pop
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        push     = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        halt_pend_d = halt_pend_q;
`endif
        case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (req_q && !imem_ack) begin
                        state_d  = ST_DROP;
                        target_d = tgt;
`ifdef IFETCH_MISALIGN_TRAP_EN
                        halt_pend_d = misal;
                    end else if (misal) begin
                        state_d = ST_HALT;
`endif
                    end else begin
                        pc_d = tgt;
                    end
                end else begin
                    push = acked;
                    pop  = instr_valid && instr_ready;
                    if (acked) pc_d = pc_q + 32'd4;
                end
            end
            ST_DROP: begin
                if (redirect_valid) begin
                    flush    = 1'b1;
                    target_d = tgt;
`ifdef IFETCH_MISALIGN_TRAP_EN
                    halt_pend_d = misal;
`endif
                end
                if (acked) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
                    if (halt_pend_d) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                        pc_d    = target_d;
                    end
`else
                    state_d = ST_FETCH;
                    pc_d    = target_d;
`endif
                end
            end
`ifdef IFETCH_MISALIGN_TRAP_EN
            ST_HALT: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (!misal) begin
                        state_d = ST_FETCH;
                        pc_d    = tgt;
                    end
                end
            end
`endif
            default: state_d = ST_FETCH;
        endcase

        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end

        // An unacked request is held; otherwise only request when a slot is guaranteed at ack
        if (req_q && !imem_ack) req_d = 1'b1;
        else                    req_d = (state_d == ST_FETCH) && (count_d < DEPTH_C);
    end

    // State, pc and FIFO pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            target_q <= RESET_PC;
            req_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            halt_pend_q <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            req_q    <= req_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
            halt_pend_q <= halt_pend_d;
            err_q       <= redirect_valid && misal;
`endif
        end
    end

    // FIFO storage: word and its fetch PC written together on push
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr_q] <= imem_rdata;
            fifo_pc[wr_ptr_q]    <= pc_q;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: directed scenarios plus a randomized run checked against a
// program-order model (next expected PC, memory word derived from the address).
module tb_ifetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;

    logic        req_a, valid_a, err_a;
    logic [31:0] addr_a, instr_a, ipc_a;
    logic        req_b, valid_b, err_b;
    logic [31:0] addr_b, instr_b, ipc_b;

    int total = 0;
    int bad   = 0;

    ifetch_unit #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .imem_req(req_a), .imem_addr(addr_a), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(valid_a), .instr_ready(instr_ready), .instr(instr_a), .instr_pc(ipc_a),
        .misalign_err(err_a)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(req_b), .imem_addr(addr_b), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(valid_b), .instr_ready(instr_ready), .instr(instr_b), .instr_pc(ipc_b),
        .misalign_err(err_b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (req_a !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", req_a); end
        total++; if (addr_a !== 32'h100) begin bad++; $display("FAIL reset_addr got=%h exp=00000100", addr_a); end
        total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
        total++; if (instr_a !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instr_a, NOP); end
        total++; if (ipc_a !== 32'h0) begin bad++; $display("FAIL reset_ipc got=%h exp=0", ipc_a); end
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_a); end
        total++; if (addr_b !== 32'hFFFF_FFF8) begin bad++; $display("FAIL reset_addr_wrap got=%h exp=fffffff8", addr_b); end
        rst = 1'b0;
        tick();
        total++; if (req_a !== 1'b1) begin bad++; $display("FAIL first_req got=%b exp=1", req_a); end
        rst = 1'b1;
        tick();
        total++; if (req_a !== 1'b0) begin bad++; $display("FAIL reset_abandon got=%b exp=0", req_a); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        int first_ack = -1;
        int first_valid = -1;
        int gaps = 0;
        int ndel = 0;
        int nreq = 0;
        logic [31:0] exp_addr = 32'h100;
        logic [31:0] exp_pc = 32'h100;
        do_reset();
        rst = 1'b0; instr_ready = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (valid_a) begin
                if (first_valid < 0) first_valid = i;
                total++;
                if (ipc_a !== exp_pc || instr_a !== mem_word(exp_pc)) begin
                    bad++; $display("FAIL seq_instr got=%h/%h exp=%h/%h", ipc_a, instr_a, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4; ndel++;
            end else if (first_valid >= 0) gaps++;
            imem_ack = req_a;
            imem_rdata = req_a ? mem_word(addr_a) : 32'hDEAD_DEAD;
            if (req_a) begin
                if (first_ack < 0) first_ack = i;
                nreq++;
                total++;
                if (addr_a !== exp_addr) begin bad++; $display("FAIL seq_addr got=%h exp=%h", addr_a, exp_addr); end
                exp_addr += 32'd4;
            end
            tick();
        end
        imem_ack = 1'b0;
        total++; if (first_valid !== first_ack + 1) begin bad++; $display("FAIL seq_latency got=%0d exp=%0d", first_valid, first_ack + 1); end
        total++; if (gaps !== 0) begin bad++; $display("FAIL seq_gaps got=%0d exp=0", gaps); end
        total++; if (ndel !== 19) begin bad++; $display("FAIL seq_count got=%0d exp=19", ndel); end
        total++; if (nreq !== 20) begin bad++; $display("FAIL seq_reqs got=%0d exp=20", nreq); end
    endtask

    task automatic test_backpressure();
        int nack = 0;
        int gaps = 0;
        logic [31:0] exp_pc = 32'h100;
        do_reset();
        rst = 1'b0;
        tick();
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            imem_ack = req_a;
            imem_rdata = mem_word(addr_a);
            if (req_a) nack++;
            tick();
        end
        imem_ack = 1'b0;
        total++; if (nack !== 2) begin bad++; $display("FAIL bp_acks got=%0d exp=2", nack); end
        total++; if (req_a !== 1'b0) begin bad++; $display("FAIL bp_req_off got=%b exp=0", req_a); end
        instr_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (valid_a) begin
                total++;
                if (ipc_a !== exp_pc || instr_a !== mem_word(exp_pc)) begin
                    bad++; $display("FAIL bp_instr got=%h/%h exp=%h/%h", ipc_a, instr_a, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4;
            end else gaps++;
            imem_ack = req_a;
            imem_rdata = mem_word(addr_a);
            tick();
        end
        imem_ack = 1'b0;
        total++; if (gaps !== 0) begin bad++; $display("FAIL bp_gaps got=%0d exp=0", gaps); end
        total++; if (exp_pc !== 32'h130) begin bad++; $display("FAIL bp_delivered got=%h exp=00000130", exp_pc); end
    endtask

    task automatic test_drop();
        do_reset();
        rst = 1'b0;
        tick();
        instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (req_a !== 1'b1 || addr_a !== 32'h100) begin
                bad++; $display("FAIL drop_hold got=%b/%h exp=1/00000100", req_a, addr_a);
            end
            if (i < 2) tick();
        end
        imem_ack = 1'b1; imem_rdata = mem_word(32'h100);
        tick();
        imem_ack = 1'b0;
        total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL drop_discard got=%b exp=0", valid_a); end
        total++;
        if (req_a !== 1'b1 || addr_a !== 32'h200) begin
            bad++; $display("FAIL drop_next_addr got=%b/%h exp=1/00000200", req_a, addr_a);
        end
        imem_ack = 1'b1; imem_rdata = mem_word(32'h200);
        tick();
        imem_ack = 1'b0;
        total++;
        if (valid_a !== 1'b1 || ipc_a !== 32'h200 || instr_a !== mem_word(32'h200)) begin
            bad++; $display("FAIL drop_first_instr got=%b/%h/%h exp=1/00000200/%h", valid_a, ipc_a, instr_a, mem_word(32'h200));
        end
    endtask

    task automatic test_redirect_ack();
        int n = 0;
        do_reset();
        rst = 1'b0; instr_ready = 1'b1;
        tick();
        while (!(valid_a && req_a) && n < 20) begin
            imem_ack = req_a; imem_rdata = mem_word(addr_a);
            tick();
            n++;
        end
        total++; if ((valid_a && req_a) !== 1'b1) begin bad++; $display("FAIL redir_setup_timeout got=%b exp=1", valid_a && req_a); end
        imem_ack = 1'b1; imem_rdata = mem_word(addr_a);
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        imem_ack = 1'b0; redirect_valid = 1'b0;
        total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b exp=0", valid_a); end
        total++; if (instr_a !== NOP || ipc_a !== 32'h0) begin bad++; $display("FAIL redir_empty_out got=%h/%h exp=%h/0", instr_a, ipc_a, NOP); end
        total++; if (req_a !== 1'b1 || addr_a !== 32'h300) begin bad++; $display("FAIL redir_addr got=%b/%h exp=1/00000300", req_a, addr_a); end
        imem_ack = 1'b1; imem_rdata = mem_word(32'h300);
        tick();
        imem_ack = 1'b0;
        total++; if (valid_a !== 1'b1 || ipc_a !== 32'h300) begin bad++; $display("FAIL redir_first got=%b/%h exp=1/00000300", valid_a, ipc_a); end
    endtask

    task automatic test_wrap();
        int nreq = 0;
        logic [31:0] exp_addr = 32'hFFFF_FFF8;
        do_reset();
        rst = 1'b0; instr_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            imem_ack = req_b; imem_rdata = mem_word(addr_b);
            if (req_b) begin
                nreq++;
                total++;
                if (addr_b !== exp_addr) begin bad++; $display("FAIL wrap_addr got=%h exp=%h", addr_b, exp_addr); end
                exp_addr += 32'd4;
            end
            tick();
        end
        imem_ack = 1'b0;
        total++; if (nreq !== 4) begin bad++; $display("FAIL wrap_reqs got=%0d exp=4", nreq); end
    endtask

    task automatic test_misalign();
        do_reset();
        rst = 1'b0; instr_ready = 1'b1;
        tick();
        imem_ack = 1'b1; imem_rdata = mem_word(32'h100);
        redirect_valid = 1'b1; redirect_pc = 32'h202;
        tick();
        imem_ack = 1'b0; redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        total++; if (err_a !== 1'b1) begin bad++; $display("FAIL mis_err_pulse got=%b exp=1", err_a); end
        total++; if (req_a !== 1'b0) begin bad++; $display("FAIL mis_no_req got=%b exp=0", req_a); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (err_a !== 1'b0 || req_a !== 1'b0) begin bad++; $display("FAIL mis_halt got=%b/%b exp=0/0", err_a, req_a); end
        end
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        tick();
        redirect_valid = 1'b0;
        total++; if (req_a !== 1'b1 || addr_a !== 32'h400) begin bad++; $display("FAIL mis_resume got=%b/%h exp=1/00000400", req_a, addr_a); end
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL mis_err_clear got=%b exp=0", err_a); end
`else
        total++; if (req_a !== 1'b1 || addr_a !== 32'h200) begin bad++; $display("FAIL mis_aligned_addr got=%b/%h exp=1/00000200", req_a, addr_a); end
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL mis_err got=%b exp=0", err_a); end
        imem_ack = 1'b1; imem_rdata = mem_word(32'h200);
        tick();
        imem_ack = 1'b0;
        total++; if (valid_a !== 1'b1 || ipc_a !== 32'h200) begin bad++; $display("FAIL mis_first got=%b/%h exp=1/00000200", valid_a, ipc_a); end
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL mis_err_late got=%b exp=0", err_a); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] exp_pc = 32'h100;
        logic [31:0] prev_addr = 32'h0;
        logic [31:0] tgt;
        logic        prev_hold = 1'b0;
        int          ndel = 0;
        do_reset();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3000; i++) begin
            if (prev_hold) begin
                total++;
                if (req_a !== 1'b1 || addr_a !== prev_addr) begin
                    bad++; $display("FAIL rnd_hold cyc=%0d got=%b/%h exp=1/%h", i, req_a, addr_a, prev_addr);
                end
            end
            total++; if (addr_a[1:0] !== 2'b00) begin bad++; $display("FAIL rnd_align cyc=%0d got=%h", i, addr_a); end
            total++; if (err_a !== 1'b0) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=0", i, err_a); end
            if (!valid_a) begin
                total++;
                if (instr_a !== NOP || ipc_a !== 32'h0) begin
                    bad++; $display("FAIL rnd_empty cyc=%0d got=%h/%h exp=%h/0", i, instr_a, ipc_a, NOP);
                end
            end
            instr_ready    = ($urandom_range(0, 9) < 7);
            imem_ack       = req_a && ($urandom_range(0, 9) < 6);
            imem_rdata     = imem_ack ? mem_word(addr_a) : $urandom();
            redirect_valid = ($urandom_range(0, 99) < 3);
            tgt            = $urandom();
`ifdef IFETCH_MISALIGN_TRAP_EN
            tgt[1:0]       = 2'b00;
`endif
            redirect_pc    = tgt;
            if (redirect_valid) begin
                exp_pc = {tgt[31:2], 2'b00};
            end else if (valid_a && instr_ready) begin
                total++;
                if (ipc_a !== exp_pc || instr_a !== mem_word(exp_pc)) begin
                    bad++; $display("FAIL rnd_instr cyc=%0d got=%h/%h exp=%h/%h", i, ipc_a, instr_a, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4;
                ndel++;
            end
            prev_hold = req_a && !imem_ack;
            prev_addr = addr_a;
            tick();
        end
        redirect_valid = 1'b0; imem_ack = 1'b0;
        total++; if (ndel < 300) begin bad++; $display("FAIL rnd_throughput got=%0d exp>=300", ndel); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_drop();
        test_redirect_ack();
        test_wrap();
        test_misalign();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
